alu_packet_sender: RTL and testbench

ALU_PACKET_SENDER -- requirements
Module: alu_packet_sender

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_rsp_collector.sv | 45 ++++
 rtl/alu_packet_sender.sv | 142 ++++++++++++++
 tb/tb_alu_packet_sender.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM states, opcode constants and framing lengths for the ALU packet link
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        WAIT_RSP,
        RSP_OUT
    } state_t;

    localparam logic [7:0] OP_ADD = 8'h10;
    localparam logic [7:0] OP_SUB = 8'h11;
    localparam logic [7:0] OP_AND = 8'h12;
    localparam logic [7:0] OP_OR  = 8'h13;
    localparam logic [7:0] OP_XOR = 8'h14;

    localparam int HDR_LEN = 4;
    localparam int RSP_LEN = 4;

    // Total packet length in bytes: header plus four bytes per operand.
    function automatic logic [15:0] pkt_len(input logic [2:0] count);
        return 16'(HDR_LEN) + 16'({count, 2'b00});
    endfunction

endpackage

// File: rtl/alu_rsp_collector.sv
// alu_rsp_collector: assembles the 4-byte little-endian ALU result and watches for a response timeout
module alu_rsp_collector
    import alu_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_P = 32'd100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        active_i,
    input  logic        rx_fire_i,
    input  logic [7:0]  rx_byte_i,
    output logic [31:0] result_o,
    output logic        done_o,
    output logic        timeout_o
);

    logic [1:0]  nbytes;
    logic [31:0] ticks;

    // An arriving byte always beats expiry, so a timeout is only declared on an idle cycle.
    assign done_o    = active_i & rx_fire_i & (nbytes == 2'(RSP_LEN - 1));
    assign timeout_o = active_i & ~rx_fire_i & (ticks == TIMEOUT_P - 32'd1);

    // Counters sit at zero outside the wait window; the result is kept for the output phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            nbytes   <= '0;
            ticks    <= '0;
            result_o <= '0;
        end else if (!active_i) begin
            nbytes <= '0;
            ticks  <= '0;
        end else if (rx_fire_i) begin
            result_o <= {rx_byte_i, result_o[31:8]};
            nbytes   <= nbytes + 2'd1;
            ticks    <= '0;
        end else if (timeout_o) begin
            result_o <= '0;
            ticks    <= '0;
        end else begin
            ticks <= ticks + 32'd1;
        end
    end

endmodule

// File: rtl/alu_packet_sender.sv
// alu_packet_sender: frames an ALU command into a UART byte packet and returns the 32-bit result
module alu_packet_sender
    import alu_pkg::*;
#(
    parameter int          DATA_WIDTH_P   = 8,
    parameter int          MAX_OPERANDS_P = 4,
    parameter logic [31:0] TIMEOUT_P      = 32'd100000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [7:0]                  cmd_opcode_i,
    input  logic [2:0]                  cmd_count_i,
    input  logic [32*MAX_OPERANDS_P-1:0] cmd_operands_i,
    output logic [DATA_WIDTH_P-1:0]     tx_data_o,
    output logic                        tx_valid_o,
    input  logic                        tx_ready_i,
    input  logic [DATA_WIDTH_P-1:0]     rx_data_i,
    input  logic                        rx_valid_i,
    output logic                        rx_ready_o,
    output logic [31:0]                 rsp_data_o,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic                        err_o,
    output logic                        busy_o
);

    localparam int OP_W  = 32 * MAX_OPERANDS_P;
    localparam int IDX_W = $clog2(OP_W);

    state_t              state;
    logic [7:0]          opcode;
    logic [2:0]          count;
    logic [OP_W-1:0]     operands;
    logic [15:0]         pos;
    logic [15:0]         len;
    logic [15:0]         pidx;
    logic [IDX_W-1:0]    bit_idx;
    logic [7:0]          tx_byte;
    logic                legal;
    logic                tx_fire;
    logic                rx_fire;
    logic                rsp_done;
    logic                rsp_timeout;

    // pos counts bytes of the whole packet; payload bytes map straight onto the flat operand vector.
    assign len     = pkt_len(count);
    assign pidx    = pos - 16'(HDR_LEN);
    assign bit_idx = IDX_W'({pidx, 3'b000});
    assign legal   = (cmd_count_i != 3'd0) && (32'(cmd_count_i) <= 32'(MAX_OPERANDS_P));

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign tx_valid_o  = (state == HDR) || (state == PAYLOAD);
    assign rx_ready_o  = (state != RSP_OUT);
    assign rsp_valid_o = (state == RSP_OUT);
    assign tx_fire     = tx_valid_o & tx_ready_i;
    assign rx_fire     = rx_valid_i & rx_ready_o;
    assign tx_data_o   = DATA_WIDTH_P'(tx_byte);

    // Byte on the wire is a pure function of held state, so it cannot move during a stall.
    always_comb begin
        tx_byte = 8'h00;
        if (state == HDR)
            tx_byte = (pos[1:0] == 2'd0) ? opcode :
                      (pos[1:0] == 2'd1) ? 8'h00 :
                      (pos[1:0] == 2'd2) ? len[7:0] : len[15:8];
        else if (state == PAYLOAD)
            tx_byte = operands[bit_idx +: 8];
    end

    alu_rsp_collector #(
        .TIMEOUT_P (TIMEOUT_P)
    ) u_collector (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .active_i  (state == WAIT_RSP),
        .rx_fire_i (rx_fire),
        .rx_byte_i (rx_data_i[7:0]),
        .result_o  (rsp_data_o),
        .done_o    (rsp_done),
        .timeout_o (rsp_timeout)
    );

    // Packet framing FSM; err_o is a registered single-cycle pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            opcode   <= '0;
            count    <= '0;
            operands <= '0;
            pos      <= '0;
            err_o    <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        if (legal) begin
                            opcode   <= cmd_opcode_i;
                            count    <= cmd_count_i;
                            operands <= cmd_operands_i;
                            pos      <= '0;
                            state    <= HDR;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (tx_fire) begin
                        pos <= pos + 16'd1;
                        if (pos == 16'(HDR_LEN - 1))
                            state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (tx_fire) begin
                        pos <= pos + 16'd1;
                        if (pos == len - 16'd1)
                            state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_done) begin
                        state <= RSP_OUT;
                    end else if (rsp_timeout) begin
                        err_o <= 1'b1;
                        state <= IDLE;
                    end
                end
                RSP_OUT: begin
                    if (rsp_ready_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_packet_sender.sv
// tb_alu_packet_sender: directed and randomized checks of packet framing, response assembly, errors and reset
module tb_alu_packet_sender;
    import alu_pkg::*;

    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [7:0]   cmd_opcode_i;
    logic [2:0]   cmd_count_i;
    logic [32*M-1:0] cmd_operands_i;
    logic [7:0]   tx_data_o;
    logic         tx_valid_o;
    logic         tx_ready_i;
    logic [7:0]   rx_data_i;
    logic         rx_valid_i;
    logic         rx_ready_o;
    logic [31:0]  rsp_data_o;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic         err_o;
    logic         busy_o;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    alu_packet_sender #(
        .DATA_WIDTH_P   (8),
        .MAX_OPERANDS_P (M),
        .TIMEOUT_P      (32'd20)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_opcode_i   (cmd_opcode_i),
        .cmd_count_i    (cmd_count_i),
        .cmd_operands_i (cmd_operands_i),
        .tx_data_o      (tx_data_o),
        .tx_valid_o     (tx_valid_o),
        .tx_ready_i     (tx_ready_i),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_ready_o     (rx_ready_o),
        .rsp_data_o     (rsp_data_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .err_o          (err_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready_o), 1);
        chk({tag, "_tx_valid"}, 32'(tx_valid_o), 0);
        chk({tag, "_tx_data"}, 32'(tx_data_o), 0);
        chk({tag, "_rx_ready"}, 32'(rx_ready_o), 1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 0);
        chk({tag, "_rsp_data"}, rsp_data_o, 0);
        chk({tag, "_err"}, 32'(err_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    task automatic offer(input logic [7:0] op, input logic [2:0] cnt, input logic [32*M-1:0] ops);
        cmd_valid_i    = 1'b1;
        cmd_opcode_i   = op;
        cmd_count_i    = cnt;
        cmd_operands_i = ops;
        tick();
        cmd_valid_i    = 1'b0;
        cmd_opcode_i   = 8'($urandom);
        cmd_count_i    = 3'($urandom);
        cmd_operands_i = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Reference packet: opcode, 0, 16-bit LE length, then each operand LSB first.
    task automatic send_pkt(input logic [7:0] op, input int cnt, input logic [32*M-1:0] ops,
                            input int mode, input int stop);
        int total;
        int got;
        int cyc;
        bit stalled;
        bit rdy;
        logic [7:0] held;
        logic [31:0] w;
        total = 4 + 4 * cnt;
        exp_q = {};
        exp_q.push_back(op);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(total % 256));
        exp_q.push_back(8'(total / 256));
        for (int k = 0; k < cnt; k++) begin
            w = ops[32*k +: 32];
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'((w >> (8 * b)) % 256));
        end
        offer(op, 3'(cnt), ops);
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        held = 8'h00;
        while (got < stop && cyc < 1000) begin
            chk("tx_valid_hi", 32'(tx_valid_o), 1);
            if (stalled)
                chk("tx_stable", 32'(tx_data_o), 32'(held));
            held = tx_data_o;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom % 2);
            tx_ready_i = rdy;
            rx_valid_i = 1'($urandom % 2);
            rx_data_i  = 8'($urandom);
            tick();
            cyc++;
            if (rdy) begin
                chk("tx_byte", 32'(held), 32'(exp_q[got]));
                got++;
            end
            stalled = !rdy;
        end
        chk("tx_count", 32'(got), 32'(stop));
        tx_ready_i = 1'b0;
        rx_valid_i = 1'b0;
    endtask

    task automatic send_rsp(input logic [31:0] val, input int nbytes, input int max_gap);
        int gap;
        for (int i = 0; i < nbytes; i++) begin
            chk("rx_ready_wait", 32'(rx_ready_o), 1);
            rx_data_i  = 8'((val >> (8 * i)) % 256);
            rx_valid_i = 1'b1;
            tick();
            rx_valid_i = 1'b0;
            rx_data_i  = 8'($urandom);
            if (i < nbytes - 1) begin
                gap = $urandom_range(0, max_gap);
                repeat (gap) begin
                    chk("rsp_valid_early", 32'(rsp_valid_o), 0);
                    tick();
                end
            end
        end
    endtask

    task automatic finish_rsp(input logic [31:0] val, input int hold);
        chk("rsp_valid", 32'(rsp_valid_o), 1);
        chk("rsp_data", rsp_data_o, val);
        chk("rsp_cmd_ready", 32'(cmd_ready_o), 0);
        chk("rsp_rx_ready", 32'(rx_ready_o), 0);
        chk("rsp_tx_valid", 32'(tx_valid_o), 0);
        repeat (hold) begin
            tick();
            chk("rsp_hold_valid", 32'(rsp_valid_o), 1);
            chk("rsp_hold_data", rsp_data_o, val);
            chk("rsp_hold_cmd_ready", 32'(cmd_ready_o), 0);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid_o), 0);
        chk("post_rsp_busy", 32'(busy_o), 0);
        chk("post_rsp_cmd_ready", 32'(cmd_ready_o), 1);
    endtask

    initial begin
        logic [32*M-1:0] ops;
        logic [7:0] opcodes[5];
        logic [31:0] val;
        int cnt;
        int n;
        opcodes = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
        rst = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_opcode_i = '0;
        cmd_count_i = '0;
        cmd_operands_i = '0;
        tx_ready_i = 1'b0;
        rx_data_i = '0;
        rx_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset("reset");

        // Directed example packet with an always-ready transmitter.
        ops = {64'h0, 32'h0000_0005, 32'h0000_0003};
        send_pkt(8'h10, 2, ops, 0, 12);
        chk("wait_tx_valid", 32'(tx_valid_o), 0);
        chk("wait_busy", 32'(busy_o), 1);
        send_rsp(32'h0000_0008, 4, 0);
        finish_rsp(32'h0000_0008, 0);

        // Same command with a stalling transmitter and a held-off result consumer.
        send_pkt(8'h10, 2, ops, 1, 12);
        val = $urandom;
        send_rsp(val, 4, 5);
        finish_rsp(val, 10);

        // Illegal operand counts are consumed with a one-cycle error pulse.
        foreach (opcodes[i]) begin
            if (i < 3) begin
                cnt = (i == 0) ? 0 : (i == 1) ? 5 : 7;
                offer(opcodes[i], 3'(cnt), {$urandom, $urandom, $urandom, $urandom});
                chk("bad_err", 32'(err_o), 1);
                chk("bad_tx_valid", 32'(tx_valid_o), 0);
                chk("bad_cmd_ready", 32'(cmd_ready_o), 1);
                chk("bad_busy", 32'(busy_o), 0);
                tick();
                chk("bad_err_clear", 32'(err_o), 0);
                chk("bad_tx_valid2", 32'(tx_valid_o), 0);
            end
        end

        // Partial response: the error pulse lands TIMEOUT_P cycles after the last byte.
        send_pkt(OP_SUB, 1, {$urandom, $urandom, $urandom, $urandom}, 0, 8);
        send_rsp(32'hA5C3_1234, 2, 0);
        n = 0;
        while (!err_o && n < 100) begin
            chk("to_rsp_valid", 32'(rsp_valid_o), 0);
            tick();
            n++;
        end
        chk("to_latency", 32'(n), 20);
        chk("to_busy", 32'(busy_o), 0);
        chk("to_cmd_ready", 32'(cmd_ready_o), 1);
        chk("to_rsp_valid_end", 32'(rsp_valid_o), 0);
        tick();
        chk("to_err_clear", 32'(err_o), 0);

        // Reset after the fifth byte abandons the packet.
        ops = {$urandom, $urandom, $urandom, $urandom};
        send_pkt(OP_XOR, 3, ops, 0, 5);
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_tx_valid", 32'(tx_valid_o), 0);
        send_pkt(OP_AND, 3, ops, 0, 16);
        val = $urandom;
        send_rsp(val, 4, 3);
        finish_rsp(val, 2);

        // Randomized commands, transmitter stalls and response gaps.
        for (int t = 0; t < 8; t++) begin
            cnt = $urandom_range(1, M);
            ops = {$urandom, $urandom, $urandom, $urandom};
            send_pkt(opcodes[$urandom_range(0, 4)], cnt, ops, 2, 4 + 4 * cnt);
            val = $urandom;
            send_rsp(val, 4, 8);
            finish_rsp(val, $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
